init_reset_sequencer: RTL and testbench

Consumer side of the PolarFire SoC init monitor. It takes the asynchronous init-done and POR status outputs plus the fabric PLL lock, and synchronises them. It then sequences a clean, debounced, registered fabric reset release for the Mi-V RV32 subsystem and LSRAM test logic. It also flags a timeout if device or RAM initialisation never completes.

---
 rtl/init_reset_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_init_reset_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/init_reset_sequencer.sv
// Fabric reset sequencer for the PolarFire SoC init monitor outputs.
// Synchronises the init/POR/lock status and releases a qualified, registered fabric reset.
module init_reset_sequencer #(
   parameter int unsigned SYNC_STAGES        = 2,
   parameter int unsigned LOCK_STABLE_CYCLES = 16,
   parameter int unsigned HOLD_CYCLES        = 32,
   parameter int unsigned TIMEOUT_CYCLES     = 1000000,
   parameter bit          REQUIRE_SRAM       = 1'b1
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       fabric_por_n_i,
   input  logic       device_init_done_i,
   input  logic       sram_init_done_i,
   input  logic       usram_init_done_i,
   input  logic       pll_lock_i,
   input  logic       ext_rst_n_i,
   output logic       fabric_reset_n_o,
   output logic       init_complete_o,
   output logic       timeout_err_o,
   output logic [2:0] seq_state_o
);

   localparam int unsigned LW = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_INIT = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_HOLD      = 3'd3,
      ST_RUN       = 3'd4,
      ST_ERROR     = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] lock_cnt_q, lock_cnt_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          fabric_reset_n_q, fabric_reset_n_d;
   logic          init_complete_q, init_complete_d;
   logic          timeout_err_q, timeout_err_d;

   logic [5:0]    async_in;
   logic [5:0]    sync_q [SYNC_STAGES];
   logic          por_s, device_init_s, sram_s, usram_s, lock_s, ext_rst_n_s;
   logic          init_ok_s;
   logic          tmo_hit_s;
   logic [TW-1:0] tmo_inc_s;

   assign async_in = {ext_rst_n_i, pll_lock_i, usram_init_done_i,
                      sram_init_done_i, device_init_done_i, fabric_por_n_i};

   // Synchroniser chain shared by all six asynchronous status inputs
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= 6'b000000;
         end
      end else begin
         sync_q[0] <= async_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign por_s         = sync_q[SYNC_STAGES-1][0];
   assign device_init_s = sync_q[SYNC_STAGES-1][1];
   assign sram_s        = sync_q[SYNC_STAGES-1][2];
   assign usram_s       = sync_q[SYNC_STAGES-1][3];
   assign lock_s        = sync_q[SYNC_STAGES-1][4];
   assign ext_rst_n_s   = sync_q[SYNC_STAGES-1][5];

   assign init_ok_s = device_init_s & ((!REQUIRE_SRAM) | (sram_s & usram_s));
   assign tmo_hit_s = (tmo_cnt_q == TMO_LAST);
   // Saturating increment: the timeout counter must never wrap back to zero
   assign tmo_inc_s = tmo_hit_s ? tmo_cnt_q : (tmo_cnt_q + TW'(1'b1));

   // Next-state, counter and registered-output decode
   always_comb begin
      state_d          = state_q;
      lock_cnt_d       = lock_cnt_q;
      hold_cnt_d       = hold_cnt_q;
      tmo_cnt_d        = tmo_cnt_q;
      init_complete_d  = init_complete_q;
      timeout_err_d    = timeout_err_q;
      fabric_reset_n_d = 1'b0;

      if (!por_s || !ext_rst_n_s) begin
         state_d    = ST_IDLE;
         lock_cnt_d = {LW{1'b0}};
         hold_cnt_d = {HW{1'b0}};
         tmo_cnt_d  = {TW{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d   = ST_WAIT_INIT;
               tmo_cnt_d = {TW{1'b0}};
            end
            ST_WAIT_INIT: begin
               if (tmo_hit_s) begin
                  state_d = ST_ERROR;
               end else begin
                  tmo_cnt_d = tmo_inc_s;
                  if (init_ok_s) begin
                     state_d    = ST_WAIT_LOCK;
                     lock_cnt_d = {LW{1'b0}};
                  end else begin
                     state_d = ST_WAIT_INIT;
                  end
               end
            end
            ST_WAIT_LOCK: begin
               if (tmo_hit_s) begin
                  state_d = ST_ERROR;
               end else begin
                  tmo_cnt_d = tmo_inc_s;
                  if (!lock_s) begin
                     lock_cnt_d = {LW{1'b0}};
                  end else if (lock_cnt_q == LOCK_LAST) begin
                     state_d    = ST_HOLD;
                     lock_cnt_d = {LW{1'b0}};
                     hold_cnt_d = {HW{1'b0}};
                  end else begin
                     lock_cnt_d = lock_cnt_q + LW'(1'b1);
                  end
               end
            end
            ST_HOLD: begin
               if (!lock_s) begin
                  state_d    = ST_WAIT_LOCK;
                  hold_cnt_d = {HW{1'b0}};
                  lock_cnt_d = {LW{1'b0}};
               end else if (hold_cnt_q == HOLD_LAST) begin
                  state_d    = ST_RUN;
                  hold_cnt_d = {HW{1'b0}};
               end else begin
                  hold_cnt_d = hold_cnt_q + HW'(1'b1);
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state_d    = ST_WAIT_LOCK;
                  tmo_cnt_d  = {TW{1'b0}};
                  lock_cnt_d = {LW{1'b0}};
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_ERROR: begin
               state_d = ST_ERROR;
            end
            default: begin
               state_d    = ST_IDLE;
               lock_cnt_d = {LW{1'b0}};
               hold_cnt_d = {HW{1'b0}};
               tmo_cnt_d  = {TW{1'b0}};
            end
         endcase
      end

      // Outputs follow the next state so they change on the same edge as SEQ_STATE
      fabric_reset_n_d = (state_d == ST_RUN);
      case (state_d)
         ST_IDLE: begin
            init_complete_d = 1'b0;
            timeout_err_d   = 1'b0;
         end
         ST_RUN: begin
            init_complete_d = 1'b1;
         end
         ST_ERROR: begin
            timeout_err_d = 1'b1;
         end
         default: begin
            init_complete_d = init_complete_q;
            timeout_err_d   = timeout_err_q;
         end
      endcase
   end

   // State, counter and output registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q          <= ST_IDLE;
         lock_cnt_q       <= {LW{1'b0}};
         hold_cnt_q       <= {HW{1'b0}};
         tmo_cnt_q        <= {TW{1'b0}};
         fabric_reset_n_q <= 1'b0;
         init_complete_q  <= 1'b0;
         timeout_err_q    <= 1'b0;
      end else begin
         state_q          <= state_d;
         lock_cnt_q       <= lock_cnt_d;
         hold_cnt_q       <= hold_cnt_d;
         tmo_cnt_q        <= tmo_cnt_d;
         fabric_reset_n_q <= fabric_reset_n_d;
         init_complete_q  <= init_complete_d;
         timeout_err_q    <= timeout_err_d;
      end
   end

   assign fabric_reset_n_o = fabric_reset_n_q;
   assign init_complete_o  = init_complete_q;
   assign timeout_err_o    = timeout_err_q;
   assign seq_state_o      = state_q;

endmodule

// File: tb/tb_init_reset_sequencer.sv
// Scoreboard bench for init_reset_sequencer: expected output snapshots are queued
// with the edge they are due at and compared as the DUT reaches that edge.
module tb_init_reset_sequencer;

   logic       clk = 1'b0;
   logic       reset_i;
   logic       fabric_por_n_i, device_init_done_i, sram_init_done_i;
   logic       usram_init_done_i, pll_lock_i, ext_rst_n_i;
   logic       fabric_reset_n_o, init_complete_o, timeout_err_o;
   logic [2:0] seq_state_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // snapshot layout: {seq_state[2:0], fabric_reset_n, init_complete, timeout_err}
   typedef struct {
      int         cyc;
      string      name;
      logic [5:0] val;
   } exp_t;

   exp_t sb[$];

   init_reset_sequencer #(
      .SYNC_STAGES       (2),
      .LOCK_STABLE_CYCLES(4),
      .HOLD_CYCLES       (8),
      .TIMEOUT_CYCLES    (100),
      .REQUIRE_SRAM      (1'b1)
   ) dut (
      .clk_i             (clk),
      .reset_i           (reset_i),
      .fabric_por_n_i    (fabric_por_n_i),
      .device_init_done_i(device_init_done_i),
      .sram_init_done_i  (sram_init_done_i),
      .usram_init_done_i (usram_init_done_i),
      .pll_lock_i        (pll_lock_i),
      .ext_rst_n_i       (ext_rst_n_i),
      .fabric_reset_n_o  (fabric_reset_n_o),
      .init_complete_o   (init_complete_o),
      .timeout_err_o     (timeout_err_o),
      .seq_state_o       (seq_state_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive_all(input logic v);
      fabric_por_n_i     = v;
      device_init_done_i = v;
      sram_init_done_i   = v;
      usram_init_done_i  = v;
      pll_lock_i         = v;
      ext_rst_n_i        = v;
   endtask

   function automatic void expect_at(input int c, input string n, input logic [2:0] st,
                                     input logic frn, input logic ic, input logic te);
      exp_t e;
      e.cyc  = c;
      e.name = n;
      e.val  = {st, frn, ic, te};
      sb.push_back(e);
   endfunction

   task automatic restart();
      reset_i = 1'b1;
      drive_all(1'b0);
      step();
      step();
      reset_i = 1'b0;
      step();
   endtask

   task automatic test_reset();
      exp_t e;
      int   b;
      reset_i = 1'b1;
      drive_all(1'b1);
      b = cyc;
      for (int k = 1; k <= 4; k++) expect_at(b + k, "reset_hold", 3'd0, 1'b0, 1'b0, 1'b0);
      for (int k = 5; k <= 7; k++) expect_at(b + k, "idle_no_por", 3'd0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 7; k++) begin
         step();
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            checks++;
            if ({seq_state_o, fabric_reset_n_o, init_complete_o, timeout_err_o} !== e.val) begin
               failures++;
               $display("FAIL %s edge=%0d got=%b exp=%b", e.name, cyc,
                        {seq_state_o, fabric_reset_n_o, init_complete_o, timeout_err_o}, e.val);
            end
         end
         if (k == 4) begin
            reset_i = 1'b0;
            drive_all(1'b0);
         end
      end
   endtask

   task automatic test_nominal();
      exp_t e;
      int   b;
      drive_all(1'b1);
      b = cyc;
      expect_at(b + 2,  "nom_idle",        3'd0, 1'b0, 1'b0, 1'b0);
      expect_at(b + 3,  "nom_wait_init",   3'd1, 1'b0, 1'b0, 1'b0);
      expect_at(b + 4,  "nom_wait_lock",   3'd2, 1'b0, 1'b0, 1'b0);
      expect_at(b + 7,  "nom_still_lock",  3'd2, 1'b0, 1'b0, 1'b0);
      expect_at(b + 8,  "nom_hold",        3'd3, 1'b0, 1'b0, 1'b0);
      expect_at(b + 15, "nom_hold_end",    3'd3, 1'b0, 1'b0, 1'b0);
      expect_at(b + 16, "nom_run",         3'd4, 1'b1, 1'b1, 1'b0);
      expect_at(b + 19, "nom_ignore_init", 3'd4, 1'b1, 1'b1, 1'b0);
      expect_at(b + 22, "nom_run_stable",  3'd4, 1'b1, 1'b1, 1'b0);
      for (int k = 1; k <= 22; k++) begin
         step();
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            checks++;
            if ({seq_state_o, fabric_reset_n_o, init_complete_o, timeout_err_o} !== e.val) begin
               failures++;
               $display("FAIL %s edge=%0d got=%b exp=%b", e.name, cyc,
                        {seq_state_o, fabric_reset_n_o, init_complete_o, timeout_err_o}, e.val);
            end
         end
         if (k == 16) begin
            device_init_done_i = 1'b0;
            sram_init_done_i   = 1'b0;
            usram_init_done_i  = 1'b0;
         end
         if (k == 19) drive_all(1'b1);
      end
   endtask

   task automatic test_lock_loss_run();
      exp_t e;
      int   r;
      pll_lock_i = 1'b0;
      r = cyc;
      expect_at(r + 2,  "ll_still_run",  3'd4, 1'b1, 1'b1, 1'b0);
      expect_at(r + 3,  "ll_wait_lock",  3'd2, 1'b0, 1'b1, 1'b0);
      expect_at(r + 6,  "ll_qualifying", 3'd2, 1'b0, 1'b1, 1'b0);
      expect_at(r + 7,  "ll_hold",       3'd3, 1'b0, 1'b1, 1'b0);
      expect_at(r + 14, "ll_hold_end",   3'd3, 1'b0, 1'b1, 1'b0);
      expect_at(r + 15, "ll_rerun",      3'd4, 1'b1, 1'b1, 1'b0);
      for (int k = 1; k <= 15; k++) begin
         step();
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            checks++;
            if ({seq_state_o, fabric_reset_n_o, init_complete_o, timeout_err_o} !== e.val) begin
               failures++;
               $display("FAIL %s edge=%0d got=%b exp=%b", e.name, cyc,
                        {seq_state_o, fabric_reset_n_o, init_complete_o, timeout_err_o}, e.val);
            end
         end
         if (k == 1) pll_lock_i = 1'b1;
      end
   endtask

   task automatic test_reset_in_run();
      exp_t e;
      int   q;
      reset_i = 1'b1;
      q = cyc;
      expect_at(q + 1,  "rr_reset",     3'd0, 1'b0, 1'b0, 1'b0);
      expect_at(q + 3,  "rr_idle",      3'd0, 1'b0, 1'b0, 1'b0);
      expect_at(q + 4,  "rr_wait_init", 3'd1, 1'b0, 1'b0, 1'b0);
      expect_at(q + 5,  "rr_wait_lock", 3'd2, 1'b0, 1'b0, 1'b0);
      expect_at(q + 9,  "rr_hold",      3'd3, 1'b0, 1'b0, 1'b0);
      expect_at(q + 16, "rr_hold_end",  3'd3, 1'b0, 1'b0, 1'b0);
      expect_at(q + 17, "rr_run",       3'd4, 1'b1, 1'b1, 1'b0);
      for (int k = 1; k <= 17; k++) begin
         step();
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            checks++;
            if ({seq_state_o, fabric_reset_n_o, init_complete_o, timeout_err_o} !== e.val) begin
               failures++;
               $display("FAIL %s edge=%0d got=%b exp=%b", e.name, cyc,
                        {seq_state_o, fabric_reset_n_o, init_complete_o, timeout_err_o}, e.val);
            end
         end
         if (k == 1) reset_i = 1'b0;
      end
   endtask

   task automatic test_lock_glitch();
      exp_t e;
      int   b;
      restart();
      drive_all(1'b1);
      b = cyc;
      expect_at(b + 7,  "lg_locking",  3'd2, 1'b0, 1'b0, 1'b0);
      expect_at(b + 8,  "lg_restart",  3'd2, 1'b0, 1'b0, 1'b0);
      expect_at(b + 11, "lg_requal",   3'd2, 1'b0, 1'b0, 1'b0);
      expect_at(b + 12, "lg_hold",     3'd3, 1'b0, 1'b0, 1'b0);
      expect_at(b + 16, "lg_not_yet",  3'd3, 1'b0, 1'b0, 1'b0);
      expect_at(b + 19, "lg_hold_end", 3'd3, 1'b0, 1'b0, 1'b0);
      expect_at(b + 20, "lg_run",      3'd4, 1'b1, 1'b1, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         step();
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            checks++;
            if ({seq_state_o, fabric_reset_n_o, init_complete_o, timeout_err_o} !== e.val) begin
               failures++;
               $display("FAIL %s edge=%0d got=%b exp=%b", e.name, cyc,
                        {seq_state_o, fabric_reset_n_o, init_complete_o, timeout_err_o}, e.val);
            end
         end
         if (k == 5) pll_lock_i = 1'b0;
         if (k == 6) pll_lock_i = 1'b1;
      end
   endtask

   task automatic test_sram_timeout();
      exp_t e;
      int   b;
      restart();
      drive_all(1'b1);
      usram_init_done_i = 1'b0;
      b = cyc;
      expect_at(b + 3,   "to_wait_init", 3'd1, 1'b0, 1'b0, 1'b0);
      expect_at(b + 60,  "to_waiting",   3'd1, 1'b0, 1'b0, 1'b0);
      expect_at(b + 102, "to_last_wait", 3'd1, 1'b0, 1'b0, 1'b0);
      expect_at(b + 103, "to_error",     3'd5, 1'b0, 1'b0, 1'b1);
      expect_at(b + 110, "to_sticky",    3'd5, 1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 110; k++) begin
         step();
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            checks++;
            if ({seq_state_o, fabric_reset_n_o, init_complete_o, timeout_err_o} !== e.val) begin
               failures++;
               $display("FAIL %s edge=%0d got=%b exp=%b", e.name, cyc,
                        {seq_state_o, fabric_reset_n_o, init_complete_o, timeout_err_o}, e.val);
            end
         end
      end
      ext_rst_n_i = 1'b0;
      b = cyc;
      expect_at(b + 2, "ext_pending",  3'd5, 1'b0, 1'b0, 1'b1);
      expect_at(b + 3, "ext_idle",     3'd0, 1'b0, 1'b0, 1'b0);
      expect_at(b + 5, "ext_idle_end", 3'd0, 1'b0, 1'b0, 1'b0);
      expect_at(b + 6, "ext_rewait",   3'd1, 1'b0, 1'b0, 1'b0);
      expect_at(b + 8, "ext_tmo_clr",  3'd1, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         step();
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            checks++;
            if ({seq_state_o, fabric_reset_n_o, init_complete_o, timeout_err_o} !== e.val) begin
               failures++;
               $display("FAIL %s edge=%0d got=%b exp=%b", e.name, cyc,
                        {seq_state_o, fabric_reset_n_o, init_complete_o, timeout_err_o}, e.val);
            end
         end
         if (k == 3) ext_rst_n_i = 1'b1;
      end
   endtask

   task automatic test_por_drop_hold();
      exp_t e;
      int   b;
      restart();
      drive_all(1'b1);
      b = cyc;
      expect_at(b + 8,  "pd_hold",     3'd3, 1'b0, 1'b0, 1'b0);
      expect_at(b + 12, "pd_pending",  3'd3, 1'b0, 1'b0, 1'b0);
      expect_at(b + 13, "pd_idle",     3'd0, 1'b0, 1'b0, 1'b0);
      expect_at(b + 20, "pd_stay",     3'd0, 1'b0, 1'b0, 1'b0);
      expect_at(b + 30, "pd_no_run",   3'd0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 30; k++) begin
         step();
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            checks++;
            if ({seq_state_o, fabric_reset_n_o, init_complete_o, timeout_err_o} !== e.val) begin
               failures++;
               $display("FAIL %s edge=%0d got=%b exp=%b", e.name, cyc,
                        {seq_state_o, fabric_reset_n_o, init_complete_o, timeout_err_o}, e.val);
            end
         end
         if (k == 10) fabric_por_n_i = 1'b0;
      end
   endtask

   initial begin
      reset_i = 1'b1;
      drive_all(1'b0);
      test_reset();
      test_nominal();
      test_lock_loss_run();
      test_reset_in_run();
      test_lock_glitch();
      test_sram_timeout();
      test_por_drop_hold();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain pending=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
